// File: rtl/mul_rpt_add_unit.sv
// ============================================================================
// Module   : mul_rpt_add_unit
// Brief    : Sequential unsigned multiplier, a*b by repeated addition,
//            with start/busy/done handshake and optional min/max operand swap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_rpt_add_unit #(
  parameter int WIDTH    = 8,
  parameter int SWAP_MIN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ADD   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_zero = '0;

  state_t               r_state;
  logic [WIDTH-1:0]     r_count;
  logic [WIDTH-1:0]     r_addend;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_busy;
  logic                 r_done;

  logic [WIDTH-1:0]     w_count_ld;
  logic [WIDTH-1:0]     w_addend_ld;

  // Loop on the smaller operand when swapping; on a tie the counter takes a.
  generate
    if (SWAP_MIN != 0) begin : g_swap
      logic w_b_lt_a;
      assign w_b_lt_a    = (b < a);
      assign w_count_ld  = w_b_lt_a ? b : a;
      assign w_addend_ld = w_b_lt_a ? a : b;
    end else begin : g_noswap
      assign w_count_ld  = b;
      assign w_addend_ld = a;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_addend  <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_count   <= w_count_ld;
            r_addend  <= w_addend_ld;
            r_product <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_count == c_zero) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_product <= r_product + {{WIDTH{1'b0}}, r_addend};
          r_count   <= r_count - c_one;
          // Last add happens on the edge that sees a pre-decrement count of one.
          if (r_count == c_one) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

`default_nettype wire
